// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and special-case bypass for divides.
module muldiv_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t          state, state_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] hi, hi_d, lo, lo_d, bm, bm_d;
   logic            sa, sa_d, sb, sb_d, spec, spec_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            busy_d, done_d;
   logic [XLEN-1:0] result_d;

   // Operand decode for the request being presented
   logic            rs1_signed, rs2_signed, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0] mag1, mag2;

   assign rs1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
   assign rs2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
   assign neg1       = rs1_signed & rs1[XLEN-1];
   assign neg2       = rs2_signed & rs2[XLEN-1];
   assign mag1       = neg1 ? (~rs1 + XLEN'(1)) : rs1;
   assign mag2       = neg2 ? (~rs2 + XLEN'(1)) : rs2;
   assign div_zero   = op[2] && (rs2 == '0);
   assign div_ovf    = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

   // One iteration of each algorithm; hi/lo are shared between them
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
   assign div_shift = {hi, lo[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, bm};
   assign prod      = {hi, lo};
   assign prod_s    = (sa ^ sb) ? (~prod + (2*XLEN)'(1)) : prod;
   assign quo_s     = (!spec && (sa ^ sb)) ? (~lo + XLEN'(1)) : lo;
   assign rem_s     = (!spec && sa) ? (~hi + XLEN'(1)) : hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         hi     <= '0;
         lo     <= '0;
         bm     <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         spec   <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_d;
         op_q   <= op_d;
         hi     <= hi_d;
         lo     <= lo_d;
         bm     <= bm_d;
         sa     <= sa_d;
         sb     <= sb_d;
         spec   <= spec_d;
         cnt    <= cnt_d;
         busy   <= busy_d;
         done   <= done_d;
         result <= result_d;
      end
   end

   always_comb begin
      state_d  = state;
      op_d     = op_q;
      hi_d     = hi;
      lo_d     = lo;
      bm_d     = bm;
      sa_d     = sa;
      sb_d     = sb;
      spec_d   = spec;
      cnt_d    = cnt;
      result_d = result;

      case (state)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d   = op;
               sa_d   = neg1;
               sb_d   = neg2;
               bm_d   = mag2;
               cnt_d  = '0;
               spec_d = div_zero || div_ovf;
               if (div_zero) begin
                  hi_d    = rs1;
                  lo_d    = '1;
                  state_d = S_FIX;
               end else if (div_ovf) begin
                  hi_d    = '0;
                  lo_d    = {1'b1, {(XLEN-1){1'b0}}};
                  state_d = S_FIX;
               end else begin
                  hi_d    = '0;
                  lo_d    = mag1;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               if (!div_diff[XLEN]) begin
                  hi_d = div_diff[XLEN-1:0];
                  lo_d = {lo[XLEN-2:0], 1'b1};
               end else begin
                  hi_d = div_shift[XLEN-1:0];
                  lo_d = {lo[XLEN-2:0], 1'b0};
               end
            end else begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo[XLEN-1:1]};
            end
            cnt_d = cnt + CW'(1);
            if (cnt == CW'(XLEN-1)) state_d = S_FIX;
         end
         S_FIX: begin
            case (op_q)
               3'b000:         result_d = prod_s[XLEN-1:0];
               3'b100, 3'b101: result_d = quo_s;
               3'b110, 3'b111: result_d = rem_s;
               default:        result_d = prod_s[2*XLEN-1:XLEN];
            endcase
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything, including a simultaneous start
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result;
      end

      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [2:0]      op = 3'b000;
   logic [XLEN-1:0] rs1 = '0;
   logic [XLEN-1:0] rs2 = '0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int n_checks = 0;
   int n_fail = 0;

   muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Present a request for one edge, then scramble operands; returns in cycle 1
   task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   // Bounded wait for done; returns cycle index of done and busy anomalies
   task automatic wait_done(output int cyc, output int busy_bad);
      cyc = 1; busy_bad = 0;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1) busy_bad++;
         @(posedge clk); #1;
         cyc++;
      end
      if (done === 1'b1 && busy !== 1'b0) busy_bad++;
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b result=%h, need 0/0/0", busy, done, result);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_mul;
      int cyc, bb;
      issue(3'b000, 32'd7, 32'hFFFF_FFFD);
      wait_done(cyc, bb);
      n_checks++;
      if (cyc !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d need 34", cyc); end
      n_checks++;
      if (bb !== 0) begin n_fail++; $display("FAIL mul_busy: %0d bad cycles need 0", bb); end
      n_checks++;
      if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h need ffffffeb", result); end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
         n_fail++; $display("FAIL mul_pulse: done=%b result=%h need 0/ffffffeb", done, result);
      end
   endtask

   task automatic test_mulh;
      logic [2:0]      ops [3] = '{3'b001, 3'b011, 3'b010};
      logic [XLEN-1:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [XLEN-1:0] bs  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [XLEN-1:0] exp [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
      int cyc, bb;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(cyc, bb);
         n_checks++;
         if (cyc !== 34 || result !== exp[i]) begin
            n_fail++;
            $display("FAIL mulh_%0d: cyc=%0d result=%h need 34/%h", i, cyc, result, exp[i]);
         end
      end
   endtask

   task automatic test_div;
      logic [2:0]      ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [XLEN-1:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [XLEN-1:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [XLEN-1:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int cyc, bb;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(cyc, bb);
         n_checks++;
         if (cyc !== 34 || bb !== 0 || result !== exp[i]) begin
            n_fail++;
            $display("FAIL div_%0d: cyc=%0d busybad=%0d result=%h need 34/0/%h", i, cyc, bb, result, exp[i]);
         end
      end
   endtask

   task automatic test_special;
      logic [2:0]      ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
      logic [XLEN-1:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [XLEN-1:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [XLEN-1:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int cyc, bb;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(cyc, bb);
         n_checks++;
         if (cyc !== 2 || bb !== 0 || result !== exp[i]) begin
            n_fail++;
            $display("FAIL special_%0d: cyc=%0d busybad=%0d result=%h need 2/0/%h", i, cyc, bb, result, exp[i]);
         end
      end
   endtask

   task automatic test_flush;
      int cyc, bb, seen;
      logic [XLEN-1:0] prev = 32'd0;
      issue(3'b000, 32'd3, 32'd5);
      for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
         n_fail++;
         $display("FAIL flush_abort: busy=%b done=%b result=%h need 0/0/%h", busy, done, result, prev);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL flush_nodone: %0d pulses need 0", seen); end
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      seen = 0;
      if (busy === 1'b1) seen++;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
      n_checks++;
      if (seen !== 0 || result !== prev) begin
         n_fail++; $display("FAIL flush_start: activity=%0d result=%h need 0/%h", seen, result, prev);
      end
      issue(3'b000, 32'd3, 32'd5);
      wait_done(cyc, bb);
      n_checks++;
      if (cyc !== 34 || bb !== 0 || result !== 32'd15) begin
         n_fail++; $display("FAIL flush_resume: cyc=%0d busybad=%0d result=%h need 34/0/0000000f", cyc, bb, result);
      end
   endtask

   task automatic test_reset_mid;
      issue(3'b100, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         n_fail++; $display("FAIL reset_mid: busy=%b done=%b result=%h need 0/0/0", busy, done, result);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      int cyc, bb;
      issue(3'b000, 32'd3, 32'd5);
      wait_done(cyc, bb);
      n_checks++;
      if (cyc !== 34 || result !== 32'd15) begin
         n_fail++; $display("FAIL b2b_first: cyc=%0d result=%h need 34/0000000f", cyc, result);
      end
      start = 1'b1; op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc, bb);
      n_checks++;
      if (cyc !== 34 || bb !== 0 || result !== 32'd14) begin
         n_fail++; $display("FAIL b2b_second: gap=%0d busybad=%0d result=%h need 34/0/0000000e", cyc, bb, result);
      end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_mulh;
      test_div;
      test_special;
      test_reset_mid;
      test_flush;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
